// File: rtl/fifo_ram_ctrl.sv
// FIFO controller around an external synchronous single-read/single-write RAM,
// with a two-entry output buffer that hides the one-cycle RAM read latency.
module fifo_ram_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH:0]   count,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic [DWIDTH-1:0] ram_d,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_raddr,
  output logic              ram_ren,
  input  logic [DWIDTH-1:0] ram_q
);

  localparam int              DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] FULL  = (AWIDTH + 1)'(DEPTH);

  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [AWIDTH:0]   r_mem_count;
  logic              r_rd_pending;
  logic [1:0]        r_buf_count;
  logic [DWIDTH-1:0] r_head;
  logic [DWIDTH-1:0] r_skid;
  logic [AWIDTH:0]   r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occ;
  logic [1:0]        w_buf_after_pop;
  logic [1:0]        w_buf_count_next;
  logic [DWIDTH-1:0] w_head_next;
  logic [DWIDTH-1:0] w_skid_next;
  logic [AWIDTH:0]   w_mem_count_next;
  logic [AWIDTH:0]   w_count_next;

  assign in_ready  = (r_mem_count < FULL) & ~rst;
  assign out_valid = (r_buf_count != 2'd0);
  assign out_data  = r_head;
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;
  // Only issue a read if the word is guaranteed a buffer slot when it lands.
  assign w_occ   = {1'b0, r_buf_count} + {2'b00, r_rd_pending} - {2'b00, w_pop};
  assign w_issue = (r_mem_count != {(AWIDTH + 1){1'b0}}) & (w_occ < 3'd2);

  assign ram_we    = w_push;
  assign ram_waddr = r_wptr;
  assign ram_d     = in_data;
  assign ram_ren   = w_issue;
  assign ram_raddr = r_rptr;

  // Output buffer next state: pop shifts skid to head, capture fills first free slot.
  always_comb begin
    w_head_next      = r_head;
    w_skid_next      = r_skid;
    w_buf_after_pop  = r_buf_count - {1'b0, w_pop};
    w_buf_count_next = w_buf_after_pop;
    if (w_pop) begin
      w_head_next = r_skid;
    end else begin
      w_head_next = r_head;
    end
    if (r_rd_pending) begin
      w_buf_count_next = w_buf_after_pop + 2'd1;
      if (w_buf_after_pop == 2'd0) begin
        w_head_next = ram_q;
      end else begin
        w_skid_next = ram_q;
      end
    end else begin
      w_buf_count_next = w_buf_after_pop;
    end
  end

  // Occupancy bookkeeping; count is the registered sum of all holding stages.
  always_comb begin
    w_mem_count_next = r_mem_count + (AWIDTH + 1)'(w_push) - (AWIDTH + 1)'(w_issue);
    w_count_next     = w_mem_count_next + (AWIDTH + 1)'(w_issue)
                     + (AWIDTH + 1)'(w_buf_count_next);
  end

  // State registers; reset discards in-flight and buffered words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= {AWIDTH{1'b0}};
      r_rptr       <= {AWIDTH{1'b0}};
      r_mem_count  <= {(AWIDTH + 1){1'b0}};
      r_rd_pending <= 1'b0;
      r_buf_count  <= 2'd0;
      r_head       <= {DWIDTH{1'b0}};
      r_skid       <= {DWIDTH{1'b0}};
      r_count      <= {(AWIDTH + 1){1'b0}};
    end else begin
      r_wptr       <= w_push ? r_wptr + {{(AWIDTH - 1){1'b0}}, 1'b1} : r_wptr;
      r_rptr       <= w_issue ? r_rptr + {{(AWIDTH - 1){1'b0}}, 1'b1} : r_rptr;
      r_mem_count  <= w_mem_count_next;
      r_rd_pending <= w_issue;
      r_buf_count  <= w_buf_count_next;
      r_head       <= w_head_next;
      r_skid       <= w_skid_next;
      r_count      <= w_count_next;
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: queue-based occupancy/order model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fifo_ram_ctrl;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic [3:0] ram_waddr;
  logic [7:0] ram_d;
  logic       ram_we;
  logic [3:0] ram_raddr;
  logic       ram_ren;
  logic [7:0] ram_q = 8'd0;

  logic [7:0] ram [DEPTH];

  fifo_ram_ctrl #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count),
    .ram_waddr(ram_waddr), .ram_d(ram_d), .ram_we(ram_we),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // External synchronous RAM
  always @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_d;
    if (ram_ren) ram_q <= ram[ram_raddr];
  end

  int n_chk = 0;
  int n_fail = 0;

  // Model: words sitting in RAM, one word in flight, words in the output buffer
  logic [7:0] mem_q[$];
  logic [7:0] outq[$];
  logic [7:0] popped[$];
  bit         pend;
  logic [7:0] pend_w;
  int         wcnt;
  int         rcnt;
  bit         last_pop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mem_q.delete();
    outq.delete();
    popped.delete();
    pend = 1'b0;
    pend_w = 8'd0;
    wcnt = 0;
    rcnt = 0;
    last_pop = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_ren"}, 32'(ram_ren), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  // One cycle: drive at negedge, compare against model, then advance model.
  task automatic tick(input bit v, input logic [7:0] d, input bit r);
    bit push, pop, issue, ev;
    @(negedge clk);
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
    ev = (outq.size() > 0);
    chk("in_ready", 32'(in_ready), 32'(mem_q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) chk("out_data", 32'(out_data), 32'(outq[0]));
    chk("count", 32'(count), 32'(mem_q.size() + int'(pend) + outq.size()));
    push  = v && (mem_q.size() < DEPTH);
    pop   = ev && r;
    issue = (mem_q.size() > 0) && ((outq.size() + int'(pend) - int'(pop)) < 2);
    chk("ram_we", 32'(ram_we), 32'(push));
    if (push) begin
      chk("ram_waddr", 32'(ram_waddr), 32'(wcnt % DEPTH));
      chk("ram_d", 32'(ram_d), 32'(d));
    end
    chk("ram_ren", 32'(ram_ren), 32'(issue));
    if (issue) chk("ram_raddr", 32'(ram_raddr), 32'(rcnt % DEPTH));
    last_pop = pop;
    if (pop) begin
      popped.push_back(outq[0]);
      void'(outq.pop_front());
    end
    if (pend) outq.push_back(pend_w);
    pend = issue;
    if (issue) begin
      pend_w = mem_q.pop_front();
      rcnt++;
    end
    if (push) begin
      mem_q.push_back(d);
      wcnt++;
    end
  endtask

  task automatic scenario_a5();
    do_reset();
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("a5_count_k", 32'(count), 32'd1);
    tick(1'b0, 8'h00, 1'b0);
    chk("a5_valid_k1", 32'(out_valid), 32'd0);
    tick(1'b0, 8'h00, 1'b0);
    chk("a5_valid_k2", 32'(out_valid), 32'd1);
    chk("a5_data_k2", 32'(out_data), 32'hA5);
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    chk("a5_valid_k7", 32'(out_valid), 32'd1);
    chk("a5_data_k7", 32'(out_data), 32'hA5);
    chk("a5_count_k7", 32'(count), 32'd1);
  endtask

  initial begin
    int cycles;
    #1;
    chk_all_zero("por");
    model_clear();

    scenario_a5();

    // Fill with consumer stalled: 16 in RAM + 2 buffered
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b1, 8'(i), 1'b0);
    repeat (4) tick(1'b0, 8'h00, 1'b0);
    chk("full_count", 32'(count), 32'd18);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_accepted", 32'(wcnt), 32'd18);
    repeat (30) tick(1'b0, 8'h00, 1'b1);
    chk("full_drained", 32'(popped.size()), 32'd18);
    for (int j = 0; j < popped.size(); j++) chk("full_order", 32'(popped[j]), 32'(j));

    // Streaming, 45 words: pointers wrap twice
    do_reset();
    for (int i = 0; i < 45; i++) begin
      tick(1'b1, 8'(i), 1'b1);
      if (i >= 4) begin
        chk("stream_count", 32'(count), 32'd3);
        chk("stream_pop", 32'(last_pop), 32'd1);
      end
    end
    for (int j = 0; j < popped.size(); j++) chk("stream_order", 32'(popped[j]), 32'(j));

    // Random traffic
    do_reset();
    cycles = 0;
    while (wcnt < 1000 && cycles < 20000) begin
      tick(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 1) == 1));
      cycles++;
    end
    chk("rand_pushed", 32'(wcnt), 32'd1000);
    repeat (40) tick(1'b0, 8'h00, 1'b1);
    chk("rand_popped", 32'(popped.size()), 32'(wcnt));
    chk("rand_empty", 32'(count), 32'd0);

    // Asynchronous reset with a read in flight and a buffered word
    do_reset();
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h33, 1'b0);
    chk("mid_count", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    model_clear();
    scenario_a5();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
